data_mem_handler: RTL and testbench

- Sits between the core's load/store stage and the 4096×32 word RAM.
- Converts byte, halfword and word load/store requests into single-port word accesses.
- Sub-word stores use a read-modify-write sequence; loads are sign- or zero-extended.
- Accounts for the RAM's one-cycle registered read latency and presents a busy/done handshake to the core.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_lane_align.sv | 38 +++
 rtl/data_mem_handler.sv | 138 +++++++++++++
 tb/tb_data_mem_handler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory handler and its lane logic.
package mem_pkg;

  localparam int ADDR_W = 12;
  localparam int OFF_W  = 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_WRITE,
    S_FAULT
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane extraction with extension for loads, and lane merge for stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rd_word[8*offset +: 8];
    half_lane = offset[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {24'h0, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data = {16'h0, half_lane};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    merge_data = rd_word;
    case (funct3)
      F3_B:    merge_data[8*offset +: 8] = wdata[7:0];
      F3_H:    merge_data[16*offset[1] +: 16] = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/data_mem_handler.sv
// Load/store front end for a single-port registered-read word RAM; sub-word
// stores are done as read-modify-write, loads are sign/zero-extended.
module data_mem_handler
  import mem_pkg::*;
#(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx_q;
  logic [OFF_W-1:0]  off_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [2:0]        f3_q;
  logic              store_q;

  logic              req;
  logic              legal;
  logic              aligned;
  logic [31:0]       load_val;
  logic [31:0]       merge_val;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr[31:OFF_W+ADDR_W];
  assign req            = read_req | write_req;

  always_comb begin
    legal = 1'b0;
    if (write_req)
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    aligned = 1'b1;
    if ((funct3 == F3_H) || (funct3 == F3_HU))
      aligned = ~addr[0];
    else if (funct3 == F3_W)
      aligned = (addr[1:0] == 2'b00);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (!legal || !aligned)               state_nx = S_FAULT;
          else if (write_req && funct3 == F3_W) state_nx = S_WRITE;
          else                                  state_nx = S_ISSUE;
        end
      end
      S_ISSUE:   state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = store_q ? S_WRITE : S_IDLE;
      S_WRITE:   state_nx = S_IDLE;
      S_FAULT:   state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  mem_lane_align u_align (
    .rd_word    (ram_rdata),
    .wdata      (wdata_q),
    .offset     (off_q),
    .funct3     (f3_q),
    .load_data  (load_val),
    .merge_data (merge_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      rdata   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            idx_q   <= addr[OFF_W +: ADDR_W];
            off_q   <= addr[OFF_W-1:0];
            wdata_q <= wdata;
            f3_q    <= funct3;
            store_q <= write_req;
          end
        end
        S_CAPTURE: begin
          if (store_q) begin
            merge_q <= merge_val;
          end else begin
            rdata <= load_val;
            done  <= 1'b1;
          end
        end
        S_WRITE: done <= 1'b1;
        S_FAULT: begin
          done <= 1'b1;
          err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Word stores skip the merge path, so their data comes straight from the latch.
  assign ram_wdata = (f3_q == F3_W) ? wdata_q : merge_q;
  assign ram_addr  = idx_q;
  assign ram_we    = (state == S_WRITE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_data_mem_handler.sv
// Directed self-checking bench for data_mem_handler with a behavioural RAM.
module tb_data_mem_handler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_req = 1'b0;
  logic        write_req = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rdata;
  logic        done, err, busy;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata = '0;

  logic [31:0] mem [0:4095];
  int          we_count = 0;
  logic [11:0] last_we_addr = '0;

  int asserts = 0;
  int failures = 0;

  data_mem_handler #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .read_req  (read_req),
    .write_req (write_req),
    .addr      (addr),
    .wdata     (wdata),
    .funct3    (funct3),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      we_count      <= we_count + 1;
      last_we_addr  <= ram_addr;
    end
    ram_rdata <= mem[ram_addr];
  end

  // Issue one request at a negedge; returns cycles from accept edge to done (-1 on timeout).
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output int lat, output logic e);
    @(negedge clk);
    read_req = rd; write_req = wr; addr = a; wdata = wd; funct3 = f3;
    @(negedge clk);
    read_req = 1'b0; write_req = 1'b0;
    lat = -1; e = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i; e = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    asserts++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b done=%b err=%b we=%b, required all 0", busy, done, err, ram_we);
    end
    asserts++;
    if (rdata !== 32'h0 || ram_addr !== 12'h0) begin
      failures++;
      $display("FAIL reset_data: rdata=%h ram_addr=%h, required 0/0", rdata, ram_addr);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    int lat; logic e; int w0;
    w0 = we_count;
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, lat, e);
    asserts++;
    if (lat !== 1 || e !== 1'b0) begin
      failures++;
      $display("FAIL sw_latency: lat=%0d err=%b, required 1/0", lat, e);
    end
    @(negedge clk);
    asserts++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL sw_done_pulse: done=%b, required 0", done);
    end
    asserts++;
    if (we_count - w0 !== 1 || last_we_addr !== 12'd4 || mem[4] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_write: writes=%0d addr=%0d mem=%h, required 1/4/deadbeef", we_count - w0, last_we_addr, mem[4]);
    end
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, lat, e);
    asserts++;
    if (lat !== 2 || e !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL lw: lat=%0d err=%b rdata=%h, required 2/0/deadbeef", lat, e, rdata);
    end
  endtask

  task automatic test_sub_store();
    int lat; logic e; int w0;
    do_req(1'b0, 1'b1, 32'h10, 32'h11223344, 3'b010, lat, e);
    w0 = we_count;
    do_req(1'b0, 1'b1, 32'h12, 32'h000000AB, 3'b000, lat, e);
    @(negedge clk);
    asserts++;
    if (lat !== 3 || e !== 1'b0 || mem[4] !== 32'h11AB3344 || we_count - w0 !== 1) begin
      failures++;
      $display("FAIL sb_rmw: lat=%0d err=%b mem=%h writes=%0d, required 3/0/11ab3344/1", lat, e, mem[4], we_count - w0);
    end
    do_req(1'b0, 1'b1, 32'h14, 32'h01020304, 3'b010, lat, e);
    do_req(1'b0, 1'b1, 32'h16, 32'h1234CAFE, 3'b001, lat, e);
    @(negedge clk);
    asserts++;
    if (lat !== 3 || mem[5] !== 32'hCAFE0304 || mem[4] !== 32'h11AB3344) begin
      failures++;
      $display("FAIL sh_rmw: lat=%0d mem5=%h mem4=%h, required 3/cafe0304/11ab3344", lat, mem[5], mem[4]);
    end
  endtask

  task automatic test_extension();
    int lat; logic e;
    do_req(1'b0, 1'b1, 32'h10, 32'h80FF7F00, 3'b010, lat, e);
    do_req(1'b1, 1'b0, 32'h12, 32'h0, 3'b000, lat, e);
    asserts++;
    if (lat !== 2 || rdata !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL lb: lat=%0d rdata=%h, required 2/ffffffff", lat, rdata);
    end
    do_req(1'b1, 1'b0, 32'h13, 32'h0, 3'b100, lat, e);
    asserts++;
    if (lat !== 2 || rdata !== 32'h00000080) begin
      failures++;
      $display("FAIL lbu: lat=%0d rdata=%h, required 2/00000080", lat, rdata);
    end
    do_req(1'b1, 1'b0, 32'h12, 32'h0, 3'b001, lat, e);
    asserts++;
    if (lat !== 2 || rdata !== 32'hFFFF80FF) begin
      failures++;
      $display("FAIL lh: lat=%0d rdata=%h, required 2/ffff80ff", lat, rdata);
    end
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 3'b101, lat, e);
    asserts++;
    if (lat !== 2 || e !== 1'b0 || rdata !== 32'h00007F00) begin
      failures++;
      $display("FAIL lhu: lat=%0d err=%b rdata=%h, required 2/0/00007f00", lat, e, rdata);
    end
  endtask

  task automatic test_faults();
    int lat; logic e; int w0;
    w0 = we_count;
    do_req(1'b1, 1'b0, 32'h11, 32'h0, 3'b010, lat, e);
    asserts++;
    if (lat !== 1 || e !== 1'b1 || rdata !== 32'h00007F00) begin
      failures++;
      $display("FAIL lw_misaligned: lat=%0d err=%b rdata=%h, required 1/1/00007f00", lat, e, rdata);
    end
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 3'b011, lat, e);
    asserts++;
    if (lat !== 1 || e !== 1'b1) begin
      failures++;
      $display("FAIL load_f3_011: lat=%0d err=%b, required 1/1", lat, e);
    end
    do_req(1'b0, 1'b1, 32'h10, 32'h55555555, 3'b100, lat, e);
    asserts++;
    if (lat !== 1 || e !== 1'b1) begin
      failures++;
      $display("FAIL store_f3_100: lat=%0d err=%b, required 1/1", lat, e);
    end
    do_req(1'b0, 1'b1, 32'h13, 32'h55555555, 3'b001, lat, e);
    asserts++;
    if (lat !== 1 || e !== 1'b1) begin
      failures++;
      $display("FAIL sh_misaligned: lat=%0d err=%b, required 1/1", lat, e);
    end
    @(negedge clk);
    asserts++;
    if (we_count - w0 !== 0 || mem[4] !== 32'h80FF7F00 || err !== 1'b0) begin
      failures++;
      $display("FAIL fault_no_write: writes=%0d mem=%h err=%b, required 0/80ff7f00/0", we_count - w0, mem[4], err);
    end
  endtask

  task automatic test_handshake();
    int lat; logic e; int w0; int seen;
    // Both requests high: store wins.
    w0 = we_count;
    do_req(1'b1, 1'b1, 32'h20, 32'hA5A5C3C3, 3'b010, lat, e);
    @(negedge clk);
    asserts++;
    if (lat !== 1 || we_count - w0 !== 1 || mem[8] !== 32'hA5A5C3C3) begin
      failures++;
      $display("FAIL both_req: lat=%0d writes=%0d mem8=%h, required 1/1/a5a5c3c3", lat, we_count - w0, mem[8]);
    end
    // Store request raised while busy with a load is dropped.
    w0 = we_count;
    @(negedge clk);
    read_req = 1'b1; addr = 32'h20; funct3 = 3'b010;
    @(negedge clk);
    read_req = 1'b0; write_req = 1'b1; addr = 32'h24; wdata = 32'h12345678; funct3 = 3'b010;
    asserts++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_flag: busy=%b, required 1", busy);
    end
    @(negedge clk);
    write_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    asserts++;
    if (seen !== 1 || we_count - w0 !== 0 || rdata !== 32'hA5A5C3C3) begin
      failures++;
      $display("FAIL busy_ignore: dones=%0d writes=%0d rdata=%h, required 1/0/a5a5c3c3", seen, we_count - w0, rdata);
    end
    // New request presented in the done cycle is accepted.
    do_req(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 3'b010, lat, e);
    read_req = 1'b1; addr = 32'h10; funct3 = 3'b010;
    @(negedge clk);
    read_req = 1'b0;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    asserts++;
    if (lat !== 2 || rdata !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL req_in_done: lat=%0d rdata=%h, required 2/cafef00d", lat, rdata);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = we_count;
    @(negedge clk);
    write_req = 1'b1; addr = 32'h12; wdata = 32'h00000055; funct3 = 3'b000;
    @(negedge clk);
    write_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    asserts++;
    if (busy !== 1'b0 || done !== 1'b0 || rdata !== 32'h0 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b rdata=%h we=%b, required 0/0/0/0", busy, done, rdata, ram_we);
    end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    asserts++;
    if (we_count - w0 !== 0 || mem[4] !== 32'hCAFEF00D || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort: writes=%0d mem=%h busy=%b, required 0/cafef00d/0", we_count - w0, mem[4], busy);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_sub_store();
    test_extension();
    test_faults();
    test_handshake();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
